dpram_burst_reader: RTL

//  Read-side sequencer for simple_dpram-style memories: on a start command, reads LEN words from BASE upward.

---
 rtl/dpram_rd_pkg.sv | 26 ++
 rtl/dpram_rd_skid.sv | 103 ++++++++++
 rtl/dpram_burst_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dpram_rd_pkg.sv
// Shared types and helpers for the dual-port RAM burst reader.
// The state enum and the word-count helpers used by the top level live here.
package dpram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    // Number of words addressable with addr_w address bits.
    function automatic int depth(input int addr_w);
        return int'(32'd1 << addr_w);
    endfunction

    // Bursts longer than the RAM are clamped to one full pass over it.
    function automatic int clamp_len(input int len, input int addr_w);
        if (len > depth(addr_w)) begin
            return depth(addr_w);
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/dpram_rd_skid.sv
// Two-entry valid/ready output buffer carrying {last, data}.
// The head entry drives the stream directly from flops, so the output data
// and last marker stay put while the consumer stalls. The occupancy count
// lets the read sequencer throttle RAM reads so nothing can overflow.
module dpram_rd_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic              out_last_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        occupancy_o
);

    logic              hd_v_q, hd_v_d;
    logic              hd_l_q, hd_l_d;
    logic [DATA_W-1:0] hd_d_q, hd_d_d;
    logic              sk_v_q, sk_v_d;
    logic              sk_l_q, sk_l_d;
    logic [DATA_W-1:0] sk_d_q, sk_d_d;
    logic              pop_s;

    assign pop_s       = hd_v_q & out_ready_i;
    assign out_valid_o = hd_v_q;
    assign out_last_o  = hd_l_q;
    assign out_data_o  = hd_d_q;
    assign occupancy_o = {1'b0, hd_v_q} + {1'b0, sk_v_q};

    // Next-state of both entries: push fills the first free slot, pop shifts the spare forward.
    always_comb begin
        hd_v_d = hd_v_q;
        hd_l_d = hd_l_q;
        hd_d_d = hd_d_q;
        sk_v_d = sk_v_q;
        sk_l_d = sk_l_q;
        sk_d_d = sk_d_q;
        if (flush_i) begin
            hd_v_d = 1'b0;
            sk_v_d = 1'b0;
        end else if (!hd_v_q) begin
            if (in_valid_i) begin
                hd_v_d = 1'b1;
                hd_l_d = in_last_i;
                hd_d_d = in_data_i;
            end else begin
                hd_v_d = 1'b0;
            end
        end else if (!sk_v_q) begin
            if (pop_s && in_valid_i) begin
                hd_l_d = in_last_i;
                hd_d_d = in_data_i;
            end else if (pop_s) begin
                hd_v_d = 1'b0;
            end else if (in_valid_i) begin
                sk_v_d = 1'b1;
                sk_l_d = in_last_i;
                sk_d_d = in_data_i;
            end else begin
                sk_v_d = 1'b0;
            end
        end else begin
            if (pop_s) begin
                hd_l_d = sk_l_q;
                hd_d_d = sk_d_q;
                if (in_valid_i) begin
                    sk_l_d = in_last_i;
                    sk_d_d = in_data_i;
                end else begin
                    sk_v_d = 1'b0;
                end
            end else begin
                // Full and stalled: the sequencer never pushes in this case.
                sk_v_d = 1'b1;
            end
        end
    end

    // Buffer registers with synchronous reset clearing both entries and the output data.
    always_ff @(posedge clk) begin
        if (rst) begin
            hd_v_q <= 1'b0;
            hd_l_q <= 1'b0;
            hd_d_q <= {DATA_W{1'b0}};
            sk_v_q <= 1'b0;
            sk_l_q <= 1'b0;
            sk_d_q <= {DATA_W{1'b0}};
        end else begin
            hd_v_q <= hd_v_d;
            hd_l_q <= hd_l_d;
            hd_d_q <= hd_d_d;
            sk_v_q <= sk_v_d;
            sk_l_q <= sk_l_d;
            sk_d_q <= sk_d_d;
        end
    end

endmodule

// File: rtl/dpram_burst_reader.sv
// Read-side burst sequencer for a dual-port RAM with one-cycle read latency.
// On start it reads len words from base_addr upward (wrapping modulo the RAM
// depth) and presents them as a valid/ready stream with a last marker.
// Optional feature: define DPRAM_RD_ABORT_EN to add an abort input that
// cancels a running burst, flushes buffered data and still pulses done.
module dpram_burst_reader
    import dpram_rd_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef DPRAM_RD_ABORT_EN
    input  logic              abort,
`endif
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int LEN_W = ADDR_W + 1;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;

    logic [1:0]        occ_s;
    logic              pop_s;
    logic              busy_s;
    logic              abort_hit_s;
    logic              start_ok_s;
    logic              rd_room_s;
    logic              rd_issue_s;
    logic              final_rd_s;

    assign busy_s     = (state_q == ISSUE) || (state_q == DRAIN);
    assign start_ok_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign pop_s      = m_valid && m_ready;

`ifdef DPRAM_RD_ABORT_EN
    assign abort_hit_s = abort && busy_s;
`else
    assign abort_hit_s = 1'b0;
`endif

    // Read throttle: buffered + in-flight words, less this cycle's pop, must stay below two.
    always_comb begin
        rd_room_s  = ({1'b0, occ_s} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop_s});
        rd_issue_s = 1'b0;
        if ((state_q == ISSUE) && rd_room_s && !abort_hit_s) begin
            rd_issue_s = 1'b1;
        end else begin
            rd_issue_s = 1'b0;
        end
        final_rd_s = rd_issue_s && (rem_q == LEN_W'(1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (len == LEN_W'(0)) ? DONE : ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (abort_hit_s) begin
                    state_d = DONE;
                end else if (final_rd_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (abort_hit_s) begin
                    state_d = DONE;
                end else if (pop_s && m_last) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: status flags and the RAM read port.
    always_comb begin
        busy     = busy_s;
        done     = (state_q == DONE);
        mem_r_en = rd_issue_s;
        mem_addr = addr_q;
    end

    // Address/remaining counters and in-flight tracking for the one-cycle RAM latency.
    always_comb begin
        addr_d      = addr_q;
        rem_d       = rem_q;
        infl_d      = rd_issue_s;
        infl_last_d = final_rd_s;
        if (start_ok_s) begin
            addr_d = base_addr;
            rem_d  = LEN_W'(clamp_len(int'(len), ADDR_W));
        end else if (rd_issue_s) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
        end else begin
            addr_d = addr_q;
            rem_d  = rem_q;
        end
    end

    // Counter and in-flight registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= {ADDR_W{1'b0}};
            rem_q       <= {LEN_W{1'b0}};
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    // An abort drops the word arriving from the RAM and empties the buffer.
    dpram_rd_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (abort_hit_s),
        .in_valid_i (infl_q && !abort_hit_s),
        .in_last_i  (infl_last_q),
        .in_data_i  (mem_rdata),
        .out_valid_o(m_valid),
        .out_last_o (m_last),
        .out_data_o (m_data),
        .out_ready_i(m_ready),
        .occupancy_o(occ_s)
    );

endmodule
